// File: rtl/pipelined_adder.sv
// Pipelined N-bit add/subtract unit. The carry chain is cut into STAGES
// chunks of W = N/STAGES bits; each chunk is added in its own register
// stage using the carry registered by the stage before it. A single
// global advance enable gives valid/ready flow control with backpressure.
module pipelined_adder #(
    parameter int N      = 32,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         overflow
);

    localparam int W = N / STAGES;

    // Per-stage registers: lower sum chunks already computed, operands
    // (b already conditionally inverted) still carrying the pending upper
    // chunks and the MSBs needed for the overflow flag, chunk carry, valid.
    logic [N-1:0]        sum_q  [STAGES];
    logic [N-1:0]        a_q    [STAGES];
    logic [N-1:0]        b_q    [STAGES];
    logic                carry_q[STAGES];
    logic [STAGES-1:0]   valid_q;

    logic [N-1:0]        sum_d  [STAGES];
    logic                carry_d[STAGES];

    logic [N-1:0]        b_eff;
    logic                c0;
    logic                en;

    logic [N-1:0]        op_a;
    logic [N-1:0]        op_b;
    logic                op_c;
    logic [W:0]          chunk;

    assign b_eff = sub ? ~b : b;
    assign c0    = sub ? 1'b1 : cin;

    // Whole pipeline advances unless the final stage holds an unaccepted result.
    assign en       = !valid_q[STAGES-1] || out_ready;
    assign in_ready = en;

    // Chunk adders for every stage; stage 0 reads the ports, stage k reads stage k-1.
    always_comb begin
        op_a  = '0;
        op_b  = '0;
        op_c  = 1'b0;
        chunk = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            sum_d[i]   = '0;
            carry_d[i] = 1'b0;
        end
        for (int unsigned i = 0; i < STAGES; i++) begin
            if (i == 0) begin
                op_a     = a;
                op_b     = b_eff;
                op_c     = c0;
                sum_d[i] = '0;
            end else begin
                op_a     = a_q[i-1];
                op_b     = b_q[i-1];
                op_c     = carry_q[i-1];
                sum_d[i] = sum_q[i-1];
            end
            chunk = {1'b0, op_a[i*W +: W]} + {1'b0, op_b[i*W +: W]} + {{W{1'b0}}, op_c};
            sum_d[i][i*W +: W] = chunk[W-1:0];
            carry_d[i]         = chunk[W];
        end
    end

    // Stage registers: clear on reset, shift on enable, hold on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < STAGES; i++) begin
                sum_q[i]   <= '0;
                a_q[i]     <= '0;
                b_q[i]     <= '0;
                carry_q[i] <= 1'b0;
            end
        end else if (en) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                sum_q[i]   <= sum_d[i];
                carry_q[i] <= carry_d[i];
                if (i == 0) begin
                    a_q[i]     <= a;
                    b_q[i]     <= b_eff;
                    valid_q[i] <= in_valid;
                end else begin
                    a_q[i]     <= a_q[i-1];
                    b_q[i]     <= b_q[i-1];
                    valid_q[i] <= valid_q[i-1];
                end
            end
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign cout      = carry_q[STAGES-1];
    assign overflow  = (a_q[STAGES-1][N-1] == b_q[STAGES-1][N-1]) &&
                       (sum_q[STAGES-1][N-1] != a_q[STAGES-1][N-1]);

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- N-bit add/subtract unit that splits the carry chain into STAGES equal chunks, with one register stage per chunk.
- Carries are registered between chunks, so clock frequency scales with N/STAGES rather than N.
- Provides valid/ready handshakes on input and output, global backpressure, and carry-out and signed-overflow flags.
- Used as the datapath adder in the arithmetic blocks, replacing the purely combinational ripple adder where timing is critical.

Parameters:
- N, 32, operand and result width in bits.
- STAGES, 4, number of pipeline stages. Must divide N exactly; W = N/STAGES bits per chunk. STAGES=1 is legal.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input operands valid.
- in_ready  output  1  block accepts operands this cycle.
- a  input  N  operand A.
- b  input  N  operand B.
- cin  input  1  carry-in; used only when sub=0.
- sub  input  1  0: a+b+cin; 1: a-b, computed as a+~b+1 with cin ignored.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- sum  output  N  result modulo 2^N.
- cout  output  1  carry out of bit N-1. For subtract, 1 means no borrow (a>=b unsigned).
- overflow  output  1  two's-complement signed overflow of the operation.

Behaviour:
- Reset: all stage valid bits clear. out_valid=0, sum=0, cout=0, overflow=0. rst dominates all other inputs.
- Advance enable: en = !out_valid || out_ready. in_ready = en, combinational, no dependency on in_valid.
- Input transfer: occurs when in_valid && in_ready. An input presented while in_ready=0 is not captured; the source must hold it.
- Stage 0 (en=1):
  - Computes chunk 0 (bits W-1:0) from a, b' (b, or ~b if sub), and c0 (cin, or 1 if sub).
  - Registers sum chunk 0, the chunk carry, the remaining upper chunks of a and b', and valid=in_valid&&in_ready.
- Stage k (1..STAGES-1) (en=1):
  - Adds chunk k using the carry registered by stage k-1.
  - Forwards already-computed lower sum chunks and the still-pending upper operand chunks.
  - Shifts valid.
- Stall: when en=0, every stage register holds, including valid bits and outputs. Nothing is dropped or duplicated.
- Bubbles: when en=1, invalid slots shift like valid ones.
- Latency: exactly STAGES cycles from input transfer to out_valid with no stall. Throughput is one result per cycle when out_ready=1.
- Final stage outputs:
  - sum is the concatenated chunks; cout is the final chunk carry.
  - overflow = (a[N-1] == b'[N-1]) && (sum[N-1] != a[N-1]), using the registered operand MSBs.
- Data when out_valid=0: sum, cout and overflow are don't-care, but must not be X after reset.
- Ordering: results emerge strictly in input order.
- Simultaneous input and output transfer in the same cycle is allowed and is the normal full-throughput case.
- Reset mid-stream: all in-flight operations are discarded; out_valid=0 on the cycle after rst is sampled high.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 -> out_valid=0, sum=0, cout=0, overflow=0; in_ready=1 after release.
- Full carry ripple, N=32, STAGES=4: a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 -> exactly 4 cycles later out_valid=1, sum=0x00000000, cout=1, overflow=0.
- Signed overflow: a=0x7FFFFFFF, b=1, sub=0 -> sum=0x80000000, cout=0, overflow=1. Then a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, cout=1, overflow=1.
- Subtract with borrow: a=5, b=7, cin=1, sub=1 -> sum=0xFFFFFFFE, cout=0, overflow=0 (cin ignored).
- Backpressure: stream 8 random operand pairs back-to-back and drop out_ready for 3 cycles mid-stream -> in_ready low exactly while out_valid && !out_ready; all 8 results correct, in order, no loss or duplication; scoreboard against a+b+cin.
- Reset mid-stream: assert rst with 3 ops in flight -> no stale results appear; next op after release emerges after 4 cycles. Repeat the add tests with STAGES=1 -> latency 1.
